// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns for hex digits
// (same encoding as the forward encoder path) and the reverse decode function.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef struct packed {
        logic       err;
        logic [3:0] nibble;
    } seg7_decode_t;

    typedef enum logic {CAP_WAIT, CAP_LOCKED} cap_state_t;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    // Patterns outside the hex table decode to nibble 0 with err raised.
    function automatic seg7_decode_t seg7_decode(input logic [6:0] seg_n);
        seg7_decode_t r;
        r.err    = 1'b0;
        r.nibble = 4'h0;
        case (seg_n)
            SEG_0:   r.nibble = 4'h0;
            SEG_1:   r.nibble = 4'h1;
            SEG_2:   r.nibble = 4'h2;
            SEG_3:   r.nibble = 4'h3;
            SEG_4:   r.nibble = 4'h4;
            SEG_5:   r.nibble = 4'h5;
            SEG_6:   r.nibble = 4'h6;
            SEG_7:   r.nibble = 4'h7;
            SEG_8:   r.nibble = 4'h8;
            SEG_9:   r.nibble = 4'h9;
            SEG_A:   r.nibble = 4'hA;
            SEG_B:   r.nibble = 4'hB;
            SEG_C:   r.nibble = 4'hC;
            SEG_D:   r.nibble = 4'hD;
            SEG_E:   r.nibble = 4'hE;
            SEG_F:   r.nibble = 4'hF;
            default: r.err    = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_frame_decoder_pattern.sv
// Combinational reverse decoder: active-low segment pattern to hex nibble
// plus an illegal-pattern flag.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       err
);

    seg7_decode_t dec;

    always_comb begin
        dec    = seg7_decode(seg_n);
        nibble = dec.nibble;
        err    = dec.err;
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Reads back a multiplexed 7-segment display: debounces each strobed digit,
// decodes it and hands out one word per complete frame over valid/ready.
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0]              seg_q, prev_seg;
    logic [NUM_DIGITS-1:0]   dig_q, prev_dig;
    logic [7:0]              cnt, cnt_eff;
    cap_state_t              cap_state;
    out_state_t              out_state;
    logic [NUM_DIGITS-1:0]   seen, slot_err, capture_mask;
    logic [4*NUM_DIGITS-1:0] slot_value;
    logic [3:0]              dec_nibble;
    logic                    dec_err;
    logic                    same, onehot, capture, frame_done;

    seg7_pattern_decode u_decode (
        .seg_n  (seg_q),
        .nibble (dec_nibble),
        .err    (dec_err)
    );

    // A sample that differs from its predecessor counts as the first stable
    // cycle, so STABLE_CYCLES=1 captures on the first valid sample.
    always_comb begin
        same         = (seg_q == prev_seg) && (dig_q == prev_dig);
        onehot       = $onehot(dig_q);
        cnt_eff      = same ? cnt + 8'd1 : 8'd0;
        capture      = (cap_state == CAP_WAIT) && onehot && (cnt_eff == STABLE_LAST);
        capture_mask = capture ? dig_q : '0;
        frame_done   = &seen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= '0;
            dig_q    <= '0;
            prev_seg <= '0;
            prev_dig <= '0;
        end else begin
            seg_q    <= seg_n;
            dig_q    <= dig_sel;
            prev_seg <= seg_q;
            prev_dig <= dig_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state <= CAP_WAIT;
            cnt       <= '0;
        end else begin
            case (cap_state)
                CAP_WAIT: begin
                    if (!onehot) begin
                        cnt <= '0;
                    end else if (capture) begin
                        cnt       <= '0;
                        cap_state <= CAP_LOCKED;
                    end else begin
                        cnt <= cnt_eff;
                    end
                end
                CAP_LOCKED: begin
                    if (!same) begin
                        cnt       <= '0;
                        cap_state <= CAP_WAIT;
                    end
                end
                default: begin
                    cnt       <= '0;
                    cap_state <= CAP_WAIT;
                end
            endcase
        end
    end

    // seen restarts on the edge a complete frame is consumed, but a capture
    // landing on that same edge still counts toward the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen       <= '0;
            slot_value <= '0;
            slot_err   <= '0;
        end else begin
            seen <= (frame_done ? '0 : seen) | capture_mask;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture_mask[i]) begin
                    slot_value[4*i +: 4] <= dec_nibble;
                    slot_err[i]          <= dec_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state <= OUT_EMPTY;
            out_value <= '0;
            out_err   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (out_state)
                OUT_EMPTY: begin
                    if (frame_done) begin
                        out_value <= slot_value;
                        out_err   <= slot_err;
                        out_valid <= 1'b1;
                        out_state <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (frame_done) begin
                        if (out_ready) begin
                            out_value <= slot_value;
                            out_err   <= slot_err;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_state <= OUT_EMPTY;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_state <= OUT_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
- Reverse direction of our hex-to-7-segment display path: watches the multiplexed segment/digit-strobe lines driving an N-digit display.
- Debounces each strobed pattern and decodes it back to a 4-bit hex nibble.
- Assembles one word per full display frame and hands it out over a valid/ready interface.
- Used for display readback/self-check and as a monitor in system benches.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; digit i occupies nibble [4i+3:4i].
- STABLE_CYCLES, 3, consecutive identical sampled cycles required before a digit is captured; legal range 1..255.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment lines, active-low; seg_n[0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g.
- dig_sel  input  NUM_DIGITS  digit strobe, active-high, legal only when one-hot.
- out_value  output  4*NUM_DIGITS  decoded frame, digit 0 in the LSB nibble.
- out_err  output  NUM_DIGITS  per-digit illegal-pattern flag for out_value.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset (async, rst_n=0):
  - out_value=0, out_err=0, out_valid=0, overrun=0.
  - Sample register, stability counter and seen mask cleared; capture FSM in WAIT.
- Input stage: seg_n and dig_sel registered once. All comparisons use the registered sample.
- Decode table (seg_n hex -> nibble):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
  - Any other pattern: nibble 0, err=1.
- Capture FSM, states WAIT and LOCKED:
  - WAIT: counter increments while the sample equals the previous sample and dig_sel is one-hot. Any change, or non-one-hot dig_sel (zero or multiple bits), resets the counter to 0.
  - When counter reaches STABLE_CYCLES-1, the digit is captured on that edge into slot k (k = index of the set dig_sel bit). seen[k] is set and the FSM goes to LOCKED.
  - With STABLE_CYCLES=1, a digit is captured on the first valid sample.
  - LOCKED: no further capture; any change in sample returns to WAIT with counter 0.
  - Re-capturing an already-seen slot overwrites its nibble/err. Last capture wins.
- Frame completion: the cycle after seen becomes all-ones, the frame is complete. Output FSM states are EMPTY and FULL.
  - EMPTY: load out_value/out_err, assert out_valid, go FULL, clear seen.
  - FULL with out_ready=1 in the same cycle: load the new frame, out_valid stays 1.
  - FULL with out_ready=0: frame dropped, seen cleared, overrun pulses 1 cycle, held output unchanged.
  - FULL, no new frame, out_ready=1: out_valid drops next cycle, go EMPTY.
- Handshake: out_value/out_err stable while out_valid=1 and out_ready=0. Transfer occurs on any edge where both are high.
- Latency: the first accepted sample of a digit to capture is STABLE_CYCLES+1 edges (input register plus filter). Last digit capture to out_valid is 1 edge.
- Reset mid-frame discards partial frames and the pending output, with no overrun pulse.

Decomposition:
- Shared package seg7_pkg: 7-bit segment-pattern constants for 0..F (active-low, shared with the existing encoder path) and a nibble/err decode function.
- One sub-module: seg7_pattern_decode (combinational: seg_n -> nibble, err). The top holds the filter, FSMs and output register.

Test Plan:
- Reset, then strobe digits 0..3 with patterns 79,24,30,19, each held 4 cycles -> out_valid rises with out_value=16'h4321, out_err=0.
- Same sequence with digit 2 held only 2 cycles (STABLE_CYCLES=3) -> no frame; re-strobe digit 2 for 3+ cycles -> frame 16'h4321.
- Digit 1 pattern 7F (all off) -> out_err=4'b0010, nibble 1 = 0.
- dig_sel=4'b0011 held 10 cycles -> no capture, seen unchanged.
- out_ready=0, two full frames (1234 then 5678) -> out_value stays 16'h1234 (digit 0 = 4), overrun pulses once. Then out_ready=1 -> transfer, out_valid falls.
- rst_n asserted after digits 0..2 captured, then digit 3 only -> no out_valid until all four digits are re-captured.
